// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding, default
// parameter values and the largest supported transform size.
package fft_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_BFLY_CYCLES  = 10;
  localparam int DEF_DRAIN_CYCLES = 32;
  localparam int MAX_LOG2_POINTS  = 11;

  // Wide enough for the longest phase: readout of 2^11 points takes 4096 cycles,
  // and drain/slot lengths are expected to stay well below 2^16.
  localparam int CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    READOUT,
    DONE
  } seq_state_t;

  // A transform size is usable only between 2 and 2^MAX_LOG2_POINTS points.
  function automatic logic cfg_valid(input logic [3:0] log2_n);
    return (log2_n != 4'd0) && (int'(log2_n) <= MAX_LOG2_POINTS);
  endfunction

endpackage

// File: rtl/fft_seq_counter.sv
// Loadable down-counter with terminal-count flag. The sequencer reloads it at
// the start of every butterfly slot, drain and readout phase.
module fft_seq_counter
  import fft_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the count parks at zero once it gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: steps through log2(N) butterfly stages, each followed
// by a pipeline drain, then a readout phase that strobes one address per two
// cycles. Optional feature: define FFT_SEQ_PERF_CNT_EN to add the perf_cycles
// busy-cycle counter output.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int BFLY_CYCLES  = DEF_BFLY_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            log2_points,
  output logic [3:0]            stage_number,
  output logic [3:0]            stage_level,
  output logic [ADDR_WIDTH-1:0] max_point_fft,
  output logic                  ena_fft_core,
  output logic                  ena_fft_wait,
  output logic                  ena_mul_fp_clk,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef FFT_SEQ_PERF_CNT_EN
  ,
  output logic [19:0]           perf_cycles
`endif
);

  localparam logic [CNT_WIDTH-1:0] SLOT_RELOAD  = CNT_WIDTH'(BFLY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_RELOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] bfly_left;
  logic                  cnt_load;
  logic [CNT_WIDTH-1:0]  cnt_load_value;
  logic                  cnt_tc;
  logic                  start_ok;
  logic                  last_stage;

  assign start_ok   = start && cfg_valid(log2_points);
  assign last_stage = (stage_level == (stage_number - 4'd1));

  // Decide when the shared phase counter reloads and with which length.
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    if (state == IDLE) begin
      if (start_ok) begin
        cnt_load       = 1'b1;
        cnt_load_value = SLOT_RELOAD;
      end
    end else if (abort) begin
      cnt_load       = 1'b1;
      cnt_load_value = '0;
    end else if (cnt_tc) begin
      if (state == RUN) begin
        cnt_load       = 1'b1;
        cnt_load_value = (bfly_left != '0) ? SLOT_RELOAD : DRAIN_RELOAD;
      end else if (state == DRAIN) begin
        cnt_load       = 1'b1;
        cnt_load_value = last_stage ? CNT_WIDTH'({max_point_fft, 1'b1}) : SLOT_RELOAD;
      end
    end
  end

  fft_seq_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .en        (state != IDLE),
    .load_value(cnt_load_value),
    .tc        (cnt_tc)
  );

  // Phase FSM; every output is set on the transition into the cycle it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bfly_left      <= '0;
      stage_number   <= '0;
      stage_level    <= '0;
      max_point_fft  <= '0;
      ena_fft_core   <= 1'b0;
      ena_fft_wait   <= 1'b0;
      ena_mul_fp_clk <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          state         <= RUN;
          stage_number  <= log2_points;
          stage_level   <= '0;
          max_point_fft <= ADDR_WIDTH'((32'd1 << log2_points) - 32'd1);
          bfly_left     <= ADDR_WIDTH'((32'd1 << (log2_points - 4'd1)) - 32'd1);
          ena_fft_core  <= 1'b1;
          busy          <= 1'b1;
        end else if (start) begin
          cfg_err <= 1'b1;
        end
      end else if (abort) begin
        state          <= IDLE;
        ena_fft_core   <= 1'b0;
        ena_fft_wait   <= 1'b0;
        ena_mul_fp_clk <= 1'b0;
        busy           <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (cnt_tc) begin
              if (bfly_left != '0) begin
                bfly_left <= bfly_left - 1'b1;
              end else begin
                state        <= DRAIN;
                ena_fft_core <= 1'b0;
                ena_fft_wait <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (cnt_tc) begin
              if (last_stage) begin
                state          <= READOUT;
                ena_mul_fp_clk <= 1'b1;
              end else begin
                state        <= RUN;
                stage_level  <= stage_level + 4'd1;
                bfly_left    <= max_point_fft >> 1;
                ena_fft_core <= 1'b1;
                ena_fft_wait <= 1'b0;
              end
            end
          end
          READOUT: begin
            if (cnt_tc) begin
              state          <= DONE;
              ena_fft_wait   <= 1'b0;
              ena_mul_fp_clk <= 1'b0;
              done           <= 1'b1;
            end else begin
              ena_mul_fp_clk <= ~ena_mul_fp_clk;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FFT_SEQ_PERF_CNT_EN
  // Busy-cycle count for the latest transform, held once it finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if ((state == IDLE) && start_ok) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 20'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed testbench for fft_stage_sequencer: reset state, config rejection,
// full transforms, abort, ignored restarts, async reset and the 2^11 size.
// Define FFT_SEQ_PERF_CNT_EN to also cover the perf_cycles output.
module tb_fft_stage_sequencer;

  localparam int AW = 12;
  localparam int BC = 10;
  localparam int DC = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    log2_points;
  logic [3:0]    stage_number;
  logic [3:0]    stage_level;
  logic [AW-1:0] max_point_fft;
  logic          ena_fft_core;
  logic          ena_fft_wait;
  logic          ena_mul_fp_clk;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef FFT_SEQ_PERF_CNT_EN
  logic [19:0]   perf_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  fft_stage_sequencer #(
    .ADDR_WIDTH  (AW),
    .BFLY_CYCLES (BC),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .log2_points   (log2_points),
    .stage_number  (stage_number),
    .stage_level   (stage_level),
    .max_point_fft (max_point_fft),
    .ena_fft_core  (ena_fft_core),
    .ena_fft_wait  (ena_fft_wait),
    .ena_mul_fp_clk(ena_mul_fp_clk),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
`ifdef FFT_SEQ_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] packFlags();
    return {26'd0, busy, ena_fft_core, ena_fft_wait, ena_mul_fp_clk, done, cfg_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start request (cycle 0 of a transform), optionally with abort.
  task automatic applyStimulus(input logic [3:0] n, input logic with_abort);
    start       = 1'b1;
    log2_points = n;
    abort       = with_abort;
    tick();
    start       = 1'b0;
    abort       = 1'b0;
    log2_points = 4'd0;
  endtask

  // Walks cycles 1..stop_at of a transform, comparing against the timeline
  // implied by n: stage s runs core for (2^n/2)*BC cycles then waits DC cycles,
  // readout lasts 2*2^n cycles, done follows. abort_at / spur_at drive abort or
  // a second start (log2_points=5) during that cycle; 0 disables them.
  task automatic runAndCheck(input int n, input int abort_at, input int spur_at,
                             input int stop_at);
    int run_len, stage_len, ro_start, done_c, last;
    logic b, co, w, s, d, aborted;
    run_len   = ((1 << n) / 2) * BC;
    stage_len = run_len + DC;
    ro_start  = 1 + n * stage_len;
    done_c    = ro_start + 2 * (1 << n);
    last      = (stop_at > 0) ? stop_at : done_c + 1;
    for (int c = 1; c <= last; c++) begin
      aborted = (abort_at > 0) && (c > abort_at);
      b  = 1'b0;
      co = 1'b0;
      w  = 1'b0;
      s  = 1'b0;
      d  = 1'b0;
      if (!aborted) begin
        b  = (c <= done_c);
        co = (c < ro_start) && (((c - 1) % stage_len) < run_len);
        w  = ((c < ro_start) && !co) || ((c >= ro_start) && (c < done_c));
        s  = (c >= ro_start) && (c < done_c) && (((c - ro_start) % 2) == 0);
        d  = (c == done_c);
      end
      checkOutput($sformatf("flags_n%0d_c%0d", n, c), packFlags(),
                  {26'd0, b, co, w, s, d, 1'b0});
      if (!aborted && (c < ro_start))
        checkOutput($sformatf("level_n%0d_c%0d", n, c), 32'(stage_level),
                    32'((c - 1) / stage_len));
      if (!aborted && (c <= done_c))
        checkOutput($sformatf("stage_number_n%0d_c%0d", n, c), 32'(stage_number), 32'(n));
      if (c == 1)
        checkOutput($sformatf("max_point_n%0d", n), 32'(max_point_fft), 32'((1 << n) - 1));
      abort       = (c == abort_at);
      start       = (c == spur_at);
      log2_points = (c == spur_at) ? 4'd5 : 4'd0;
      tick();
    end
    abort       = 1'b0;
    start       = 1'b0;
    log2_points = 4'd0;
  endtask

  initial begin
    logic [3:0] bad_sizes [3];
    bad_sizes[0] = 4'd0;
    bad_sizes[1] = 4'd12;
    bad_sizes[2] = 4'd15;

    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    log2_points = 4'd0;
    tick();
    tick();
    checkOutput("reset_flags", packFlags(), 32'd0);
    checkOutput("reset_stage_number", 32'(stage_number), 32'd0);
    checkOutput("reset_stage_level", 32'(stage_level), 32'd0);
    checkOutput("reset_max_point", 32'(max_point_fft), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] rejected sizes");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bad_sizes[i], 1'b0);
      checkOutput($sformatf("cfg_err_pulse_%0d", bad_sizes[i]), packFlags(), 32'h1);
      checkOutput($sformatf("cfg_err_stage_%0d", bad_sizes[i]), 32'(stage_number), 32'd0);
      checkOutput($sformatf("cfg_err_max_%0d", bad_sizes[i]), 32'(max_point_fft), 32'd0);
      tick();
      checkOutput($sformatf("cfg_err_clear_%0d", bad_sizes[i]), packFlags(), 32'd0);
    end

    $display("[TB] 4-point transform");
    applyStimulus(4'd2, 1'b0);
    runAndCheck(2, 0, 0, 0);
`ifdef FFT_SEQ_PERF_CNT_EN
    checkOutput("perf_after_done", 32'(perf_cycles), 32'd113);
`endif

    $display("[TB] abort at cycle 30, restart at cycle 35 with ignored second start");
    applyStimulus(4'd3, 1'b0);
    runAndCheck(3, 30, 0, 34);
    applyStimulus(4'd3, 1'b0);
    runAndCheck(3, 0, 5, 0);

    $display("[TB] start together with abort in IDLE");
    applyStimulus(4'd2, 1'b1);
    runAndCheck(2, 0, 0, 0);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(4'd2, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_flags", packFlags(), 32'd0);
    checkOutput("async_rst_stage_number", 32'(stage_number), 32'd0);
    checkOutput("async_rst_max_point", 32'(max_point_fft), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
    checkOutput("async_rst_perf", 32'(perf_cycles), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(4'd2, 1'b0);
    runAndCheck(2, 0, 0, 0);
`ifdef FFT_SEQ_PERF_CNT_EN
    checkOutput("perf_after_reset_run", 32'(perf_cycles), 32'd113);
`endif

    $display("[TB] 2048-point first stage");
    applyStimulus(4'd11, 1'b0);
    runAndCheck(11, 10242, 0, 10246);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
